spi_ram_arbiter: RTL and testbench

Sequencer and arbiter between the SPI slave, a local requester port and one synchronous single-port RAM. It decodes the SPI slave's 10-bit command words into RAM accesses and shares the RAM port with a local requester using round-robin arbitration. It returns read data to the SPI slave's `tx_data`/`tx_valid` inputs or to the local port.

---
 rtl/spi_ram_arbiter_if.sv | 36 +++
 rtl/spi_ram_arbiter.sv | 137 +++++++++++++
 tb/tb_spi_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_arbiter_if.sv
// Bundle of SPI-slave, local-requester and RAM-port signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface spi_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [9:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  lcl_req;
  logic                  lcl_we;
  logic [ADDR_WIDTH-1:0] lcl_addr;
  logic [7:0]            lcl_wdata;
  logic                  lcl_gnt;
  logic [7:0]            lcl_rdata;
  logic                  lcl_rvalid;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  spi_ovf;

  modport master (
    input  rx_data, rx_valid, lcl_req, lcl_we, lcl_addr, lcl_wdata, ram_rdata,
    output tx_data, tx_valid, lcl_gnt, lcl_rdata, lcl_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );

  modport slave (
    output rx_data, rx_valid, lcl_req, lcl_we, lcl_addr, lcl_wdata, ram_rdata,
    input  tx_data, tx_valid, lcl_gnt, lcl_rdata, lcl_rvalid,
           ram_en, ram_we, ram_addr, ram_wdata, spi_ovf
  );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI command words into RAM accesses and shares the single RAM port
// with a local requester under round-robin arbitration.
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  spi_ram_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

  localparam logic PRIO_SPI = 1'b0;
  localparam logic PRIO_LCL = 1'b1;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, pend_addr;
  logic [DATA_WIDTH-1:0] pend_data;
  logic                  spi_pend, pend_we, prio, cur_spi;
  logic [1:0]            opcode;
  logic                  any_req, spi_win, spi_granted, post_word;

  logic                  ram_en_d, ram_we_d, lcl_gnt_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_d;

  assign opcode      = bus.rx_data[9:8];
  assign post_word   = bus.rx_valid & opcode[0];
  assign any_req     = spi_pend | bus.lcl_req;
  assign spi_win     = spi_pend & (~bus.lcl_req | (prio == PRIO_SPI));
  assign spi_granted = (state == ACCESS) & cur_spi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ACCESS;
      ACCESS:  next_state = bus.ram_we ? IDLE : RDATA;
      RDATA:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM port values for the upcoming ACCESS cycle; zero whenever no access follows.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    lcl_gnt_d   = 1'b0;
    if (state == IDLE && any_req) begin
      ram_en_d = 1'b1;
      if (spi_win) begin
        ram_we_d    = pend_we;
        ram_addr_d  = pend_addr;
        ram_wdata_d = pend_data;
      end else begin
        ram_we_d    = bus.lcl_we;
        ram_addr_d  = bus.lcl_addr;
        ram_wdata_d = bus.lcl_wdata;
        lcl_gnt_d   = 1'b1;
      end
    end
  end

  // The pending entry snapshots its address at post time; a word posted while
  // the previous entry is in ACCESS takes over the slot instead of overflowing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ram_en     <= 1'b0;
      bus.ram_we     <= 1'b0;
      bus.ram_addr   <= '0;
      bus.ram_wdata  <= '0;
      bus.lcl_gnt    <= 1'b0;
      bus.lcl_rdata  <= '0;
      bus.lcl_rvalid <= 1'b0;
      bus.tx_data    <= '0;
      bus.tx_valid   <= 1'b0;
      bus.spi_ovf    <= 1'b0;
      wr_addr        <= '0;
      rd_addr        <= '0;
      spi_pend       <= 1'b0;
      pend_we        <= 1'b0;
      pend_addr      <= '0;
      pend_data      <= '0;
      prio           <= PRIO_SPI;
      cur_spi        <= 1'b0;
    end else begin
      bus.ram_en     <= ram_en_d;
      bus.ram_we     <= ram_we_d;
      bus.ram_addr   <= ram_addr_d;
      bus.ram_wdata  <= ram_wdata_d;
      bus.lcl_gnt    <= lcl_gnt_d;
      bus.lcl_rvalid <= 1'b0;

      if (state == IDLE && any_req) begin
        cur_spi <= spi_win;
        prio    <= spi_win ? PRIO_LCL : PRIO_SPI;
      end

      if (spi_granted) spi_pend <= 1'b0;

      if (bus.rx_valid) begin
        bus.tx_valid <= 1'b0;
        if (!opcode[0]) begin
          if (opcode[1]) rd_addr <= bus.rx_data[ADDR_WIDTH-1:0];
          else           wr_addr <= bus.rx_data[ADDR_WIDTH-1:0];
        end
      end

      if (post_word) begin
        if (!spi_pend || spi_granted) begin
          spi_pend  <= 1'b1;
          pend_we   <= ~opcode[1];
          pend_addr <= opcode[1] ? rd_addr : wr_addr;
          pend_data <= opcode[1] ? '0 : bus.rx_data[7:0];
        end else begin
          bus.spi_ovf <= 1'b1;
        end
      end

      if (state == RDATA) begin
        if (cur_spi) begin
          bus.tx_data  <= bus.ram_rdata;
          bus.tx_valid <= 1'b1;
        end else begin
          bus.lcl_rdata  <= bus.ram_rdata;
          bus.lcl_rvalid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: behavioural RAM, a time-based reference model
// compared every cycle, directed scenarios with literal checks, then random traffic.
module tb_spi_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_ram_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus();

  spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] ram_emul  [256];
  logic [7:0] model_mem [256];

  // Behavioural RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram_emul[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata <= ram_emul[bus.ram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the port is busy until free_at; each decision books the
  // access for the next cycle and, for reads, the result three cycles out.
  int         cyc, free_at, spi_acc_cyc, r_due;
  bit         r_spi, m_prio, p_valid, p_we;
  logic [7:0] r_val, m_wr, m_rd, p_addr, p_data;
  logic       e_ram_en, e_ram_we, e_lcl_gnt, e_lcl_rvalid, e_tx_valid, e_ovf;
  logic [7:0] e_ram_addr, e_ram_wdata, e_lcl_rdata, e_tx_data;

  always @(posedge clk) begin : model
    bit spi_wins;
    if (rst) begin
      cyc = 0; free_at = 0; spi_acc_cyc = -1; r_due = -1;
      r_spi = 0; r_val = 0; m_prio = 0; p_valid = 0; p_we = 0;
      m_wr = 0; m_rd = 0; p_addr = 0; p_data = 0;
      e_ram_en = 0; e_ram_we = 0; e_ram_addr = 0; e_ram_wdata = 0;
      e_lcl_gnt = 0; e_lcl_rvalid = 0; e_lcl_rdata = 0;
      e_tx_valid = 0; e_tx_data = 0; e_ovf = 0;
    end else begin
      e_ram_en = 0; e_ram_we = 0; e_ram_addr = 0; e_ram_wdata = 0;
      e_lcl_gnt = 0; e_lcl_rvalid = 0;
      if (cyc >= free_at && (p_valid || bus.lcl_req)) begin
        spi_wins = p_valid && (!bus.lcl_req || !m_prio);
        m_prio   = spi_wins;
        e_ram_en = 1;
        if (spi_wins) begin
          e_ram_we = p_we; e_ram_addr = p_addr; e_ram_wdata = p_data;
          spi_acc_cyc = cyc + 1;
        end else begin
          e_ram_we = bus.lcl_we; e_ram_addr = bus.lcl_addr; e_ram_wdata = bus.lcl_wdata;
          e_lcl_gnt = 1;
        end
        if (e_ram_we) begin
          model_mem[e_ram_addr] = e_ram_wdata;
          free_at = cyc + 2;
        end else begin
          r_val = model_mem[e_ram_addr]; r_spi = spi_wins;
          r_due = cyc + 3; free_at = cyc + 3;
        end
      end
      if (spi_acc_cyc == cyc) p_valid = 0;
      if (bus.rx_valid) begin
        e_tx_valid = 0;
        case (bus.rx_data[9:8])
          2'b00: m_wr = bus.rx_data[7:0];
          2'b10: m_rd = bus.rx_data[7:0];
          default: begin
            if (!p_valid) begin
              p_valid = 1;
              p_we    = (bus.rx_data[9:8] == 2'b01);
              p_addr  = p_we ? m_wr : m_rd;
              p_data  = p_we ? bus.rx_data[7:0] : 8'h00;
            end else begin
              e_ovf = 1;
            end
          end
        endcase
      end
      if (r_due == cyc + 1) begin
        if (r_spi) begin e_tx_data = r_val; e_tx_valid = 1; end
        else begin e_lcl_rdata = r_val; e_lcl_rvalid = 1; end
      end
      cyc++;
    end
  end

  // Compare away from both clock edges.
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      checkOutput("ram_en", 32'(bus.ram_en), 32'(e_ram_en));
      checkOutput("ram_we", 32'(bus.ram_we), 32'(e_ram_we));
      checkOutput("ram_addr", 32'(bus.ram_addr), 32'(e_ram_addr));
      if (e_ram_en && e_ram_we) checkOutput("ram_wdata", 32'(bus.ram_wdata), 32'(e_ram_wdata));
      checkOutput("lcl_gnt", 32'(bus.lcl_gnt), 32'(e_lcl_gnt));
      checkOutput("lcl_rvalid", 32'(bus.lcl_rvalid), 32'(e_lcl_rvalid));
      checkOutput("lcl_rdata", 32'(bus.lcl_rdata), 32'(e_lcl_rdata));
      checkOutput("tx_valid", 32'(bus.tx_valid), 32'(e_tx_valid));
      checkOutput("tx_data", 32'(bus.tx_data), 32'(e_tx_data));
      checkOutput("spi_ovf", 32'(bus.spi_ovf), 32'(e_ovf));
    end
  end

  task automatic applyStimulus(input logic [9:0] word);
    bus.rx_data  = word;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ram_en"}, 32'(bus.ram_en), 32'h0);
    checkOutput({tag, "_ram_we"}, 32'(bus.ram_we), 32'h0);
    checkOutput({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'h0);
    checkOutput({tag, "_lcl_gnt"}, 32'(bus.lcl_gnt), 32'h0);
    checkOutput({tag, "_lcl_rvalid"}, 32'(bus.lcl_rvalid), 32'h0);
    checkOutput({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'h0);
    checkOutput({tag, "_tx_data"}, 32'(bus.tx_data), 32'h0);
    checkOutput({tag, "_spi_ovf"}, 32'(bus.spi_ovf), 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.lcl_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic localAccess(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                             output int gnt_lat, output int rv_lat, output logic [7:0] rdata);
    int k = 0;
    gnt_lat = -1; rv_lat = -1; rdata = 8'h00;
    bus.lcl_req = 1'b1; bus.lcl_we = we; bus.lcl_addr = addr; bus.lcl_wdata = wdata;
    while (gnt_lat < 0 && k < 20) begin
      @(negedge clk); k++;
      if (bus.lcl_gnt) gnt_lat = k;
    end
    @(negedge clk); k++;
    bus.lcl_req = 1'b0;
    if (!we) begin
      while (rv_lat < 0 && k < 20) begin
        if (bus.lcl_rvalid) begin rv_lat = k; rdata = bus.lcl_rdata; end
        else begin @(negedge clk); k++; end
      end
    end
  endtask

  initial begin : main
    int         gl, rl, found;
    logic [7:0] rd, old9;
    bit         holding, release_req;
    logic [1:0] op;
    logic [7:0] payload;

    bus.rx_data = '0; bus.rx_valid = 1'b0;
    bus.lcl_req = 1'b0; bus.lcl_we = 1'b0; bus.lcl_addr = '0; bus.lcl_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram_emul[i]  = 8'($urandom);
      model_mem[i] = ram_emul[i];
    end

    doReset();
    checkAllZero("reset");

    // Contention: SPI first, then local; a word posted during the SPI grant is kept.
    applyStimulus(10'h166);
    bus.lcl_req = 1'b1; bus.lcl_we = 1'b1; bus.lcl_addr = 8'h20; bus.lcl_wdata = 8'h77;
    @(negedge clk);
    checkOutput("cont_spi_first_en", 32'(bus.ram_en & bus.ram_we), 32'h1);
    checkOutput("cont_spi_first_wdata", 32'(bus.ram_wdata), 32'h66);
    checkOutput("cont_spi_first_gnt", 32'(bus.lcl_gnt), 32'h0);
    applyStimulus(10'h199);
    @(negedge clk);
    checkOutput("cont_lcl_second_gnt", 32'(bus.lcl_gnt), 32'h1);
    checkOutput("cont_lcl_second_addr", 32'(bus.ram_addr), 32'h20);
    @(negedge clk);
    bus.lcl_req = 1'b0;
    @(negedge clk);
    checkOutput("cont_spi_third_wdata", 32'(bus.ram_wdata), 32'h99);
    checkOutput("cont_spi_third_en", 32'(bus.ram_en & bus.ram_we), 32'h1);
    repeat (4) @(negedge clk);

    // SPI write then read, words 12 cycles apart.
    doReset();
    applyStimulus(10'h005); repeat (11) @(negedge clk);
    applyStimulus(10'h1A5); repeat (11) @(negedge clk);
    applyStimulus(10'h205); repeat (11) @(negedge clk);
    applyStimulus(10'h300); repeat (11) @(negedge clk);
    checkOutput("spi_ram5", 32'(ram_emul[5]), 32'hA5);
    checkOutput("spi_tx_data", 32'(bus.tx_data), 32'hA5);
    checkOutput("spi_tx_valid_held", 32'(bus.tx_valid), 32'h1);
    applyStimulus(10'h005);
    checkOutput("spi_tx_valid_cleared", 32'(bus.tx_valid), 32'h0);

    // Local write then read.
    localAccess(1'b1, 8'h10, 8'h3C, gl, rl, rd);
    checkOutput("lcl_wr_gnt_lat", 32'(gl), 32'd1);
    localAccess(1'b0, 8'h10, 8'h00, gl, rl, rd);
    checkOutput("lcl_rd_gnt_lat", 32'(gl), 32'd1);
    checkOutput("lcl_rd_rvalid_lat", 32'(rl), 32'd3);
    checkOutput("lcl_rd_data", 32'(rd), 32'h3C);
    repeat (3) @(negedge clk);

    // Address isolation: a later address load does not retarget the posted write.
    old9 = ram_emul[9];
    applyStimulus(10'h005);
    applyStimulus(10'h1C3);
    applyStimulus(10'h009);
    repeat (6) @(negedge clk);
    checkOutput("iso_ram5", 32'(ram_emul[5]), 32'hC3);
    checkOutput("iso_ram9", 32'(ram_emul[9]), 32'(old9));

    // Overflow: two posts while the local port is mid-read.
    doReset();
    applyStimulus(10'h007);
    bus.lcl_req = 1'b1; bus.lcl_we = 1'b0; bus.lcl_addr = 8'h30;
    @(negedge clk);
    checkOutput("ovf_lcl_gnt", 32'(bus.lcl_gnt), 32'h1);
    bus.rx_data = 10'h111; bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.lcl_req = 1'b0;
    bus.rx_data = 10'h122;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("ovf_flag", 32'(bus.spi_ovf), 32'h1);
    checkOutput("ovf_ram7", 32'(ram_emul[7]), 32'h11);
    applyStimulus(10'h008);
    applyStimulus(10'h1EE);
    repeat (10) @(negedge clk);
    checkOutput("ovf_sticky", 32'(bus.spi_ovf), 32'h1);

    // Reset while a read is in ACCESS.
    applyStimulus(10'h203);
    applyStimulus(10'h300);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (bus.ram_en && !bus.ram_we) found = 1;
      else @(negedge clk);
    end
    checkOutput("rst_mid_found_read", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    checkAllZero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("rst_mid_no_tx", 32'(bus.tx_valid), 32'h0);
      checkOutput("rst_mid_no_rvalid", 32'(bus.lcl_rvalid), 32'h0);
    end
    applyStimulus(10'h300);
    repeat (4) @(negedge clk);
    checkOutput("rst_after_tx_valid", 32'(bus.tx_valid), 32'h1);
    checkOutput("rst_after_tx_data", 32'(bus.tx_data), 32'(ram_emul[0]));

    // Random traffic on both ports against the reference model.
    doReset();
    holding = 0; release_req = 0;
    for (int i = 0; i < 3000; i++) begin
      if (release_req) begin
        bus.lcl_req = 1'b0; holding = 0; release_req = 0;
      end else if (holding && bus.lcl_gnt) begin
        release_req = 1;
      end
      if (!holding && $urandom_range(0, 3) == 0) begin
        holding       = 1;
        bus.lcl_req   = 1'b1;
        bus.lcl_we    = 1'($urandom_range(0, 1));
        bus.lcl_addr  = 8'($urandom_range(0, 15));
        bus.lcl_wdata = 8'($urandom);
      end
      op      = 2'($urandom_range(0, 3));
      payload = 8'($urandom);
      if (!op[0]) payload[7:4] = 4'h0;
      bus.rx_data  = {op, payload};
      bus.rx_valid = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0; bus.lcl_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
